// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller: gates ray writes, stalls the ray producer after a sweep, swaps buffers only at video end-of-frame.
// Writes register one cycle after accept at 1 pixel/clk; ray_ready_out drops from sweep end until the swap cycle has passed.
module fb_swap_ctrl #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int PIXEL_WIDTH   = 9
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  output logic                   ray_ready_out,
  input  logic                   video_last_pixel_in,
  output logic                   sweep_start_out,
  output logic                   fb_wr_sel_out,
  output logic                   fb1_we_out,
  output logic                   fb2_we_out,
  output logic [15:0]            fb_wr_addr_out,
  output logic [PIXEL_WIDTH-1:0] fb_wr_data_out,
  output logic [7:0]             frame_count_out,
  output logic [7:0]             repeat_count_out,
  output logic                   addr_err_out
);

  localparam int          NUM_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [16:0] ADDR_LIMIT = 17'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_VIDEO, SWAP} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   in_range;
  logic   do_swap;
  logic   count_repeat;

  assign in_range      = ({1'b0, ray_address_in} < ADDR_LIMIT);
  assign ray_ready_out = (state == WRITE);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A video pulse that coincides with the sweep's last pixel triggers the swap, so it is not a repeat.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    do_swap      = 1'b0;
    count_repeat = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        accept       = ray_valid_in;
        count_repeat = video_last_pixel_in && !(ray_valid_in && ray_last_pixel_in);
        if (ray_valid_in && ray_last_pixel_in) begin
          state_nxt = video_last_pixel_in ? SWAP : WAIT_VIDEO;
        end
      end
      WAIT_VIDEO: begin
        if (video_last_pixel_in) begin
          state_nxt = SWAP;
        end
      end
      SWAP: begin
        state_nxt    = WRITE;
        do_swap      = 1'b1;
        count_repeat = video_last_pixel_in;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write enables use the select from the accept cycle, so a final pixel lands in the old buffer.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sweep_start_out  <= 1'b0;
      fb_wr_sel_out    <= 1'b0;
      fb1_we_out       <= 1'b0;
      fb2_we_out       <= 1'b0;
      fb_wr_addr_out   <= '0;
      fb_wr_data_out   <= '0;
      frame_count_out  <= '0;
      repeat_count_out <= '0;
      addr_err_out     <= 1'b0;
    end else begin
      sweep_start_out <= (state == IDLE) || do_swap;
      fb1_we_out      <= accept && in_range && !fb_wr_sel_out;
      fb2_we_out      <= accept && in_range && fb_wr_sel_out;
      if (accept && in_range) begin
        fb_wr_addr_out <= ray_address_in;
        fb_wr_data_out <= ray_pixel_in;
      end
      if (accept && !in_range) begin
        addr_err_out <= 1'b1;
      end
      if (do_swap) begin
        fb_wr_sel_out   <= ~fb_wr_sel_out;
        frame_count_out <= frame_count_out + 8'd1;
      end
      if (count_repeat && (repeat_count_out != 8'hFF)) begin
        repeat_count_out <= repeat_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Randomized and directed bench for fb_swap_ctrl, checked every cycle against a flag-based sweep/swap model.
module tb_fb_swap_ctrl;
  localparam int W    = 320;
  localparam int H    = 180;
  localparam int PW   = 9;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ray_valid;
  logic [15:0]   ray_addr;
  logic [PW-1:0] ray_pix;
  logic          ray_last;
  logic          video_last;
  logic          ray_ready;
  logic          sweep_start;
  logic          wr_sel;
  logic          we1;
  logic          we2;
  logic [15:0]   wr_addr;
  logic [PW-1:0] wr_data;
  logic [7:0]    frame_count;
  logic [7:0]    repeat_count;
  logic          addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fb_swap_ctrl #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
    .pixel_clk_in        (clk),
    .rst_n_in            (rst_n),
    .ray_valid_in        (ray_valid),
    .ray_address_in      (ray_addr),
    .ray_pixel_in        (ray_pix),
    .ray_last_pixel_in   (ray_last),
    .ray_ready_out       (ray_ready),
    .video_last_pixel_in (video_last),
    .sweep_start_out     (sweep_start),
    .fb_wr_sel_out       (wr_sel),
    .fb1_we_out          (we1),
    .fb2_we_out          (we2),
    .fb_wr_addr_out      (wr_addr),
    .fb_wr_data_out      (wr_data),
    .frame_count_out     (frame_count),
    .repeat_count_out    (repeat_count),
    .addr_err_out        (addr_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endfunction

  // Model: m_run = out of reset, m_wait = sweep done awaiting video, m_swap = swap cycle in progress.
  bit            m_run, m_wait, m_swap, m_sel, m_start, m_we1, m_we2, m_err;
  logic [15:0]   m_addr;
  logic [PW-1:0] m_data;
  int            m_frames, m_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_wait <= 0; m_swap <= 0; m_sel <= 0; m_start <= 0;
      m_we1 <= 0; m_we2 <= 0; m_err <= 0; m_addr <= '0; m_data <= '0;
      m_frames <= 0; m_rep <= 0;
    end else begin
      m_start <= 0;
      m_we1   <= 0;
      m_we2   <= 0;
      if (!m_run) begin
        m_run   <= 1;
        m_start <= 1;
      end else if (m_swap) begin
        m_swap   <= 0;
        m_sel    <= !m_sel;
        m_frames <= (m_frames + 1) % 256;
        m_start  <= 1;
        if (video_last) m_rep <= (m_rep < 255) ? m_rep + 1 : 255;
      end else if (m_wait) begin
        if (video_last) begin
          m_wait <= 0;
          m_swap <= 1;
        end
      end else begin
        if (video_last && !(ray_valid && ray_last)) m_rep <= (m_rep < 255) ? m_rep + 1 : 255;
        if (ray_valid) begin
          if (int'(ray_addr) < NPIX) begin
            m_we1  <= !m_sel;
            m_we2  <= m_sel;
            m_addr <= ray_addr;
            m_data <= ray_pix;
          end else begin
            m_err <= 1;
          end
          if (ray_last) begin
            if (video_last) m_swap <= 1;
            else            m_wait <= 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready",        ray_ready,    m_run && !m_wait && !m_swap);
    chk("sweep_start",  sweep_start,  m_start);
    chk("wr_sel",       wr_sel,       m_sel);
    chk("fb1_we",       we1,          m_we1);
    chk("fb2_we",       we2,          m_we2);
    chk("wr_addr",      wr_addr,      m_addr);
    chk("wr_data",      wr_data,      m_data);
    chk("frame_count",  frame_count,  m_frames);
    chk("repeat_count", repeat_count, m_rep);
    chk("addr_err",     addr_err,     m_err);
  end

  // Drive one cycle of inputs, return 1 time unit after the sampling edge, then idle the inputs.
  task automatic cyc(input bit v, input int a, input int p, input bit l, input bit vl);
    ray_valid  = v;
    ray_addr   = 16'(a);
    ray_pix    = PW'(p);
    ray_last   = l;
    video_last = vl;
    @(posedge clk);
    #1;
    ray_valid  = 0;
    ray_last   = 0;
    video_last = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int addrs[4];
    int pixs[4];
    addrs = '{0, 1, 319, 57599};
    pixs  = '{9'h1A5, 9'h003, 9'h0FF, 9'h100};
    rst_n = 0; ray_valid = 0; ray_addr = '0; ray_pix = '0; ray_last = 0; video_last = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset release and the first four writes
    cyc(0, 0, 0, 0, 0);
    chk("lit_start_first", sweep_start, 1);
    chk("lit_ready_first", ray_ready, 1);
    chk("lit_sel_first",   wr_sel, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_start_once", sweep_start, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, addrs[i], pixs[i], 0, 0);
      chk("lit_we1",  we1, 1);
      chk("lit_we2",  we2, 0);
      chk("lit_addr", wr_addr, addrs[i]);
      chk("lit_data", wr_data, pixs[i]);
    end

    // Sweep end then video pulse 150 cycles later
    cyc(1, 5, 9'h055, 1, 0);
    chk("lit_stall_start", ray_ready, 0);
    repeat (149) cyc(0, 0, 0, 0, 0);
    chk("lit_stall_end", ray_ready, 0);
    cyc(0, 0, 0, 0, 1);
    chk("lit_swap_ready", ray_ready, 0);
    chk("lit_swap_sel",   wr_sel, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_post_sel",   wr_sel, 1);
    chk("lit_post_start", sweep_start, 1);
    chk("lit_post_frame", frame_count, 1);
    chk("lit_post_ready", ray_ready, 1);
    cyc(1, 77, 9'h0AA, 0, 0);
    chk("lit_fb2_we2", we2, 1);
    chk("lit_fb2_we1", we1, 0);

    // Simultaneous last pixel and video pulse
    do_reset();
    cyc(1, 10, 9'h011, 1, 1);
    chk("lit_sim_ready", ray_ready, 0);
    chk("lit_sim_rep",   repeat_count, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_sim_sel",   wr_sel, 1);
    chk("lit_sim_rep2",  repeat_count, 0);

    // Repeat counting and saturation
    do_reset();
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("lit_rep3", repeat_count, 3);
    repeat (297) cyc(0, 0, 0, 0, 1);
    chk("lit_rep_sat", repeat_count, 255);

    // Out-of-range addresses
    do_reset();
    cyc(1, 57600, 9'h1FF, 0, 0);
    chk("lit_oor_we", {we1, we2}, 0);
    chk("lit_oor_err", addr_err, 1);
    cyc(1, 57600, 9'h1FF, 1, 0);
    chk("lit_oor_last_ready", ray_ready, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("lit_oor_sticky", addr_err, 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 99) == 0) ? 57600 + $urandom_range(0, 7935) : $urandom_range(0, 57599),
          $urandom_range(0, 511),
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 29) == 0);
    end

    // 256 swaps, then asynchronous reset while waiting for video
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1, i, i, 1, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      if (i == 254) chk("lit_frame_255", frame_count, 255);
    end
    chk("lit_frame_wrap", frame_count, 0);
    chk("lit_sel_wrap",   wr_sel, 0);
    cyc(1, 100, 9'h123, 1, 0);
    chk("lit_wait_ready", ray_ready, 0);
    cyc(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("lit_arst_ready", ray_ready, 0);
    chk("lit_arst_we",    {we1, we2}, 0);
    chk("lit_arst_start", sweep_start, 0);
    chk("lit_arst_addr",  wr_addr, 0);
    chk("lit_arst_data",  wr_data, 0);
    chk("lit_arst_rep",   repeat_count, 0);
    chk("lit_arst_err",   addr_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    chk("lit_restart_start", sweep_start, 1);
    cyc(1, 42, 9'h042, 0, 0);
    chk("lit_restart_we1", we1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Controller for the double-buffered frame buffer. It sits between the ray-casting pixel stream and the two frame-buffer RAMs. It gates ray writes into the current write buffer, stalls the ray producer once a sweep completes, and swaps buffers only at a video end-of-frame so the display never tears. It also starts each new ray sweep and reports frame and stall statistics.

## Interface
- SCREEN_WIDTH, 320, low-res columns
- SCREEN_HEIGHT, 180, low-res rows; valid write addresses are 0 .. SCREEN_WIDTH*SCREEN_HEIGHT-1 (57599)
- PIXEL_WIDTH, 9, bit 8 = shade flag, bits 7:0 = palette index
- pixel_clk_in  in  1  sole clock; all logic on its rising edge
- rst_n_in  in  1  reset, asynchronous assert, active-low
- ray_valid_in  in  1  ray pixel present
- ray_address_in  in  16  flattened low-res pixel address (any order)
- ray_pixel_in  in  PIXEL_WIDTH  pixel value
- ray_last_pixel_in  in  1  qualifies the final pixel of a sweep (sampled with valid)
- ray_ready_out  out  1  controller accepts a pixel this cycle
- video_last_pixel_in  in  1  one-cycle pulse at the last active video pixel of a frame
- sweep_start_out  out  1  one-cycle pulse: begin a new ray sweep
- fb_wr_sel_out  out  1  0 = write FB1 / display FB2; 1 = write FB2 / display FB1
- fb1_we_out, fb2_we_out  out  1 each  write enables
- fb_wr_addr_out  out  16  registered write address
- fb_wr_data_out  out  PIXEL_WIDTH  registered write data
- frame_count_out  out  8  completed swaps, wraps 255→0
- repeat_count_out  out  8  video frames shown without a new buffer, saturates at 255
- addr_err_out  out  1  sticky: an out-of-range address was dropped

## Operation
- FSM states: IDLE, WRITE, WAIT_VIDEO, SWAP.
- IDLE: entered on reset and held only while reset is asserted. On the first clock after release, the FSM moves to WRITE and sets sweep_start_out to 1.
- WRITE: ray_ready_out = 1. A pixel is accepted when ray_valid_in && ray_ready_out.
  - Accepted pixel with address < W*H: registered to the address/data outputs. The next cycle asserts fb1_we_out if fb_wr_sel_out = 0, else fb2_we_out.
  - Accepted pixel with address ≥ W*H: no write enable, and addr_err_out is set to 1. An out-of-range last pixel still ends the sweep.
- Sweep end: an accepted pixel with ray_last_pixel_in = 1 goes to SWAP if video_last_pixel_in is also high that cycle. Otherwise it goes to WAIT_VIDEO.
- WAIT_VIDEO: ray_ready_out = 0, and ray inputs are ignored. video_last_pixel_in moves the FSM to SWAP.
- SWAP (exactly one cycle): ray_ready_out = 0. At the exit edge, the block toggles fb_wr_sel_out, increments frame_count_out (modulo 256), sets sweep_start_out to 1 for one cycle, and moves to WRITE.
- repeat_count_out increments (saturating) on each video_last_pixel_in seen while in WRITE. It does not increment in WAIT_VIDEO, because that pulse triggers the swap. A video_last_pixel_in during SWAP is counted as a repeat.
- Write enables are never both high. A write enable always follows the fb_wr_sel_out value from its accept cycle, so the final pixel lands in the old write buffer even though the select toggles afterwards.

## Timing
- Reset values: ray_ready_out 0, sweep_start_out 0, fb_wr_sel_out 0, fb1_we_out 0, fb2_we_out 0, fb_wr_addr_out 0, fb_wr_data_out 0, frame_count_out 0, repeat_count_out 0, addr_err_out 0.
- Assertion of rst_n_in in any state clears everything asynchronously. Any pending write enable is dropped, with no partial swap.
- ray_ready_out is a decode of the state register only (no input-to-output combinational path).
- Write latency: accept at edge N gives the write enable, address and data valid at edge N+1, for one cycle per accepted pixel. Sustained throughput is 1 pixel per clock.
- Swap latency:
  - Last pixel accepted at cycle N and video pulse at cycle M > N: state is SWAP during M+1, then fb_wr_sel_out toggles and sweep_start_out is high during M+2, and ray_ready_out is 1 again at M+2.
  - Simultaneous case (M = N): SWAP during N+1.
- Minimum stall between sweeps is 1 cycle (SWAP).

## Test plan
- Reset release:
  - sweep_start_out is 1 for exactly one cycle at the first edge after release; ray_ready_out = 1 and fb_wr_sel_out = 0.
  - Then 4 pixels at addresses 0, 1, 319, 57599 give 4 fb1_we_out pulses with matching address/data one cycle later.
- Sweep ends (last pixel) at cycle 100, video pulse at 250:
  - ray_ready_out = 0 for cycles 101..251; SWAP during 251.
  - At 252, fb_wr_sel_out = 1, sweep_start_out = 1 and frame_count_out = 1. The next writes use fb2_we_out only.
- Simultaneous ray_last (accepted) and video_last at the same cycle: swap in the next cycle, and repeat_count_out stays 0.
- Three video pulses during a long WRITE: repeat_count_out = 3. With 300 pulses it saturates at 255.
- Address 57600 accepted: no write enable, addr_err_out stays 1 until reset. The same address with ray_last_pixel_in still enters WAIT_VIDEO.
- Assert rst_n_in mid-WAIT_VIDEO after 256 swaps (frame_count_out wrapped to 0): all outputs return to reset values immediately without a clock edge, then normal restart.
